// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF/ID boundary register with a 2-entry skid buffer, flush-to-bubble
// and a saturating decode-stall counter; in_ready depends on registered state only.
module if_id_skid_stage #(
    parameter int          DATA_W    = 32,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0]  main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, consume;

    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;
    assign stall_cnt = cnt_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d      = BUSY;
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end
            BUSY: if (accept && consume) begin
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end else if (accept) begin
                state_d      = FULL;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end else if (consume) begin
                state_d      = EMPTY;
                main_pc_d    = '0;
                main_instr_d = NOP;
            end
            FULL: if (consume) begin
                state_d      = BUSY;
                main_pc_d    = skid_pc_q;
                main_instr_d = skid_instr_q;
                skid_pc_d    = '0;
                skid_instr_d = NOP;
            end
            default: state_d = EMPTY;
        endcase
        // flush wins over every accept/consume transition; empty entries carry the bubble
        if (flush || state_d == EMPTY) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP;
            skid_pc_d    = '0;
            skid_instr_d = NOP;
        end
        cnt_d = clr_cnt ? '0
              : (out_valid && !out_ready && !flush && cnt_q != '1) ? cnt_q + CNT_W'(1)
              : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
Parametrised IF/ID pipeline boundary register with valid/ready flow control and a 2-entry skid buffer. Sits between the fetch unit and the decoder. Adds backpressure (decode stall) without combinational ready paths, flush-to-bubble, and a saturating stall-cycle counter for performance monitoring. Full throughput is one instruction per cycle.

Parameters:
DATA_W, 32, instruction width in bits
PC_W, 32, program counter width in bits
NOP_INSTR, 32'h0000_0013, bubble encoding driven on out_instr when the stage is empty or flushed (zero-extended or truncated to DATA_W)
CNT_W, 16, stall counter width in bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries; highest priority
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept; a function of registered state only
in_pc  input  PC_W  PC of the fetched instruction
in_instr  input  DATA_W  fetched instruction
out_valid  output  1  decode-side entry valid
out_ready  input  1  decoder consumes this cycle
out_pc  output  PC_W  PC of the head entry
out_instr  output  DATA_W  head instruction
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
clr_cnt  input  1  synchronous clear of stall_cnt

Behaviour:
- Storage: main entry (drives the out_* ports directly from flops) and skid entry. Each entry holds valid, pc and instr.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- State encoding: EMPTY (main=0, skid=0), BUSY (main=1, skid=0), FULL (main=1, skid=1). The combination main=0, skid=1 is illegal and must never occur.
- in_ready = 1 in EMPTY and BUSY, 0 in FULL. out_valid = main valid.
- EMPTY:
  - accept -> BUSY; main loads in_pc/in_instr.
  - Latency from accept to out_valid is 1 cycle.
- BUSY:
  - accept & consume -> BUSY; main loads the new entry.
  - accept only -> FULL; skid loads the new entry and main holds.
  - consume only -> EMPTY.
  - neither -> hold.
- FULL:
  - consume -> BUSY; main loads the skid contents and skid is cleared.
  - no consume -> hold.
  - No accept is possible because in_ready=0.
- Order is strictly FIFO; no entry is ever dropped or duplicated, except on flush.
- Empty payload: whenever main becomes invalid (consume to EMPTY, flush, reset), main loads pc=0 and instr=NOP_INSTR. out_pc and out_instr are therefore 0/NOP whenever out_valid=0.
- flush:
  - Next state is EMPTY regardless of accept or consume in the same cycle.
  - An instruction presented in the flush cycle is discarded even though in_ready may read 1.
  - A consume in the flush cycle still counts as taken by decode.
  - in_ready=1 in the cycle after flush.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt has priority over increment and sets the count to 0.
  - flush does not clear it.
- Reset (async assert, sync-safe deassert handled externally):
  - state EMPTY, out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR, stall_cnt=0.
  - Reset mid-FULL discards both entries immediately, without waiting for a clock edge.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- in_* inputs are ignored whenever no accept occurs.

Test Plan:
1. Reset then stream: out_ready=1; accept PC 0x00,0x04,0x08 with instrs 0x11,0x22,0x33 on consecutive cycles -> out_valid rises 1 cycle after the first accept; outputs appear in order one per cycle; in_ready stays 1; stall_cnt=0.
2. Backpressure fill: out_ready=0; present PC 0x10 then 0x14 -> both accepted; in_ready=0 from the next cycle; 0x18 held off; out_pc=0x10. Raise out_ready -> 0x10, 0x14, 0x18 delivered in order; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
3. Flush while FULL with a simultaneous in_valid of PC 0x20 -> next cycle out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1; 0x20 never appears at the output.
4. Async reset mid-FULL: assert rst_n=0 between clock edges -> out_valid=0, in_ready=1, stall_cnt=0 immediately, without a clock edge.
5. Counter saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Pulse clr_cnt while stalled -> 0 on the next cycle, then increments resume.
6. Random valid/ready/flush soak of 10k cycles against a reference queue model -> no loss, duplication or reordering outside flushes; main=0 with skid=1 never observed.
